// File: rtl/pwm_deadtime_gate.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gate
//
// Purpose:
//   Gate-drive stage for one H-bridge module. Turns the left/right leg
//   commands of the carrier-shifted PWM generator into four complementary
//   gate signals with a programmable dead time. All gates are blocked on
//   fault or disable. Leaving the blocked state always goes through a
//   dead-time interval into the lower switch. The upper and lower switch of
//   a leg are never on together.
//
// Configuration macro:
//   GATE_FAULT_LATCH_EN - when defined, the fault is latched. It is set by
//                         fault_in and cleared only by fault_clr while
//                         fault_in is low. When undefined, the fault follows
//                         fault_in after one register stage and fault_clr is
//                         unused.
//
// Parameters:
//   DT_W    width of the dead-time count (clk_20M cycles)
//   DT_MIN  smallest dead time ever applied; shorter requests are clamped
//
// Ports:
//   clk_20M     in   20 MHz system clock
//   reset       in   synchronous active-high reset
//   enable      in   1 = gating allowed, 0 = all gates off
//   fault_in    in   hardware fault, active high
//   fault_clr   in   pulse that clears a latched fault (latch build only)
//   dead_time   in   dead-time count, sampled when a leg enters dead time
//   PWM_left    in   left-leg command (1 = upper on)
//   PWM_right   in   right-leg command (1 = upper on)
//   gate_LU     out  left upper gate
//   gate_LL     out  left lower gate
//   gate_RU     out  right upper gate
//   gate_RL     out  right lower gate
//   fault_flag  out  registered fault/block status
//   dt_active   out  either leg is in a dead-time state
// -----------------------------------------------------------------------------
module pwm_deadtime_gate #(
    parameter int DT_W   = 16,
    parameter int DT_MIN = 10
) (
    input  logic            clk_20M,
    input  logic            reset,
    input  logic            enable,
    input  logic            fault_in,
    input  logic            fault_clr,
    input  logic [DT_W-1:0] dead_time,
    input  logic            PWM_left,
    input  logic            PWM_right,
    output logic            gate_LU,
    output logic            gate_LL,
    output logic            gate_RU,
    output logic            gate_RL,
    output logic            fault_flag,
    output logic            dt_active
);

    typedef enum logic [2:0] {
        ST_BLOCK = 3'd0,
        ST_LOW   = 3'd1,
        ST_DT_H  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DT_L  = 3'd4
    } leg_state_t;

    localparam int              LEG_L    = 0;
    localparam int              LEG_R    = 1;
    localparam logic [DT_W-1:0] CNT_ZERO = {DT_W{1'b0}};
    localparam logic [DT_W-1:0] CNT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};
    localparam logic [DT_W-1:0] DT_MIN_V = DT_W'(DT_MIN);

    // Count value loaded on entry to dead time: the interval lasts
    // max(dt, DT_MIN) cycles, the last of which is spent at count zero.
    function automatic logic [DT_W-1:0] dt_load(input logic [DT_W-1:0] dt);
        logic [DT_W-1:0] eff;
        if (dt < DT_MIN_V) begin
            eff = DT_MIN_V;
        end else begin
            eff = dt;
        end
        return eff - CNT_ONE;
    endfunction

    function automatic logic is_dt(input leg_state_t st);
        return (st == ST_DT_H) || (st == ST_DT_L);
    endfunction

    logic [1:0]      pwm_q_r;
    logic            fault_active_r;
    logic            fault_nxt_s;
    logic            block_s;
    logic [DT_W-1:0] dt_load_s;

    leg_state_t      leg_state_r [2];
    leg_state_t      leg_nxt_s   [2];
    logic [DT_W-1:0] cnt_r       [2];
    logic [DT_W-1:0] cnt_nxt_s   [2];
    // Set only while a DT_L interval was entered from HIGH; a DT_L that
    // follows BLOCK has no upper origin to fall back to.
    logic [1:0]      origin_hi_r;
    logic [1:0]      origin_hi_nxt_s;

    logic [1:0]      gate_u_r;
    logic [1:0]      gate_l_r;
    logic            dt_active_r;

`ifdef GATE_FAULT_LATCH_EN
    // Fault latch: set has priority over clear.
    always_comb begin
        if (fault_in) begin
            fault_nxt_s = 1'b1;
        end else if (fault_clr) begin
            fault_nxt_s = 1'b0;
        end else begin
            fault_nxt_s = fault_active_r;
        end
    end
`else
    logic unused_fault_clr_s;
    assign unused_fault_clr_s = fault_clr;

    // Fault follows the input through a single register stage.
    always_comb begin
        fault_nxt_s = fault_in;
    end
`endif

    assign block_s   = ~enable | fault_active_r;
    assign dt_load_s = dt_load(dead_time);

    // Per-leg next state, dead-time count and origin tracking.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            leg_nxt_s[i]       = leg_state_r[i];
            cnt_nxt_s[i]       = cnt_r[i];
            origin_hi_nxt_s[i] = origin_hi_r[i];
            if (block_s) begin
                leg_nxt_s[i]       = ST_BLOCK;
                cnt_nxt_s[i]       = CNT_ZERO;
                origin_hi_nxt_s[i] = 1'b0;
            end else begin
                case (leg_state_r[i])
                    ST_BLOCK: begin
                        leg_nxt_s[i]       = ST_DT_L;
                        cnt_nxt_s[i]       = dt_load_s;
                        origin_hi_nxt_s[i] = 1'b0;
                    end
                    ST_LOW: begin
                        if (pwm_q_r[i]) begin
                            leg_nxt_s[i] = ST_DT_H;
                            cnt_nxt_s[i] = dt_load_s;
                        end else begin
                            leg_nxt_s[i] = ST_LOW;
                        end
                    end
                    ST_DT_H: begin
                        // An expiring count wins over a reverting command.
                        if (cnt_r[i] == CNT_ZERO) begin
                            leg_nxt_s[i] = ST_HIGH;
                        end else if (!pwm_q_r[i]) begin
                            leg_nxt_s[i] = ST_LOW;
                            cnt_nxt_s[i] = CNT_ZERO;
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!pwm_q_r[i]) begin
                            leg_nxt_s[i]       = ST_DT_L;
                            cnt_nxt_s[i]       = dt_load_s;
                            origin_hi_nxt_s[i] = 1'b1;
                        end else begin
                            leg_nxt_s[i] = ST_HIGH;
                        end
                    end
                    ST_DT_L: begin
                        if (cnt_r[i] == CNT_ZERO) begin
                            leg_nxt_s[i]       = ST_LOW;
                            origin_hi_nxt_s[i] = 1'b0;
                        end else if (pwm_q_r[i] && origin_hi_r[i]) begin
                            leg_nxt_s[i]       = ST_HIGH;
                            cnt_nxt_s[i]       = CNT_ZERO;
                            origin_hi_nxt_s[i] = 1'b0;
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        leg_nxt_s[i]       = ST_BLOCK;
                        cnt_nxt_s[i]       = CNT_ZERO;
                        origin_hi_nxt_s[i] = 1'b0;
                    end
                endcase
            end
        end
    end

    // State, count, input and output registers; gates decode the next state
    // so they change on the same edge as the leg state.
    always_ff @(posedge clk_20M) begin
        if (reset) begin
            pwm_q_r        <= 2'b00;
            fault_active_r <= 1'b0;
            origin_hi_r    <= 2'b00;
            gate_u_r       <= 2'b00;
            gate_l_r       <= 2'b00;
            dt_active_r    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                leg_state_r[i] <= ST_BLOCK;
                cnt_r[i]       <= CNT_ZERO;
            end
        end else begin
            pwm_q_r        <= {PWM_right, PWM_left};
            fault_active_r <= fault_nxt_s;
            origin_hi_r    <= origin_hi_nxt_s;
            dt_active_r    <= is_dt(leg_nxt_s[LEG_L]) | is_dt(leg_nxt_s[LEG_R]);
            for (int i = 0; i < 2; i++) begin
                leg_state_r[i] <= leg_nxt_s[i];
                cnt_r[i]       <= cnt_nxt_s[i];
                gate_u_r[i]    <= (leg_nxt_s[i] == ST_HIGH);
                gate_l_r[i]    <= (leg_nxt_s[i] == ST_LOW);
            end
        end
    end

    assign gate_LU    = gate_u_r[LEG_L];
    assign gate_LL    = gate_l_r[LEG_L];
    assign gate_RU    = gate_u_r[LEG_R];
    assign gate_RL    = gate_l_r[LEG_R];
    assign fault_flag = fault_active_r;
    assign dt_active  = dt_active_r;

endmodule

// -----------------------------------------------------------------------------
// pwm_deadtime_gate_chk
//
// Purpose:
//   Property checker for pwm_deadtime_gate: no leg drives both switches, and
//   a disable forces every gate off on the following cycle.
//
// Ports:
//   clk_20M, reset, enable   same as the checked design
//   gate_LU/LL/RU/RL         gate outputs of the checked design
// -----------------------------------------------------------------------------
module pwm_deadtime_gate_chk (
    input logic clk_20M,
    input logic reset,
    input logic enable,
    input logic gate_LU,
    input logic gate_LL,
    input logic gate_RU,
    input logic gate_RL
);

    a_left_no_shoot: assert property (@(posedge clk_20M) disable iff (reset)
        !(gate_LU && gate_LL));

    a_right_no_shoot: assert property (@(posedge clk_20M) disable iff (reset)
        !(gate_RU && gate_RL));

    a_disable_blocks: assert property (@(posedge clk_20M) disable iff (reset)
        !enable |=> !(gate_LU || gate_LL || gate_RU || gate_RL));

endmodule

// File: tb/tb_pwm_deadtime_gate.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime_gate
//
// Table of input segments, each held for n cycles with the outputs
// {LU, LL, RU, RL, fault_flag, dt_active} expected after every edge of the
// segment, followed by a random stream that checks for shoot-through and
// for the minimum both-off gap whenever a leg changes side.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime_gate;

    localparam int DT_W   = 16;
    localparam int DT_MIN = 10;

    logic            clk_20M = 1'b0;
    logic            reset;
    logic            enable;
    logic            fault_in;
    logic            fault_clr;
    logic [DT_W-1:0] dead_time;
    logic            PWM_left;
    logic            PWM_right;
    logic            gate_LU;
    logic            gate_LL;
    logic            gate_RU;
    logic            gate_RL;
    logic            fault_flag;
    logic            dt_active;

    always #5 clk_20M = ~clk_20M;

    pwm_deadtime_gate #(.DT_W(DT_W), .DT_MIN(DT_MIN)) dut (
        .clk_20M   (clk_20M),
        .reset     (reset),
        .enable    (enable),
        .fault_in  (fault_in),
        .fault_clr (fault_clr),
        .dead_time (dead_time),
        .PWM_left  (PWM_left),
        .PWM_right (PWM_right),
        .gate_LU   (gate_LU),
        .gate_LL   (gate_LL),
        .gate_RU   (gate_RU),
        .gate_RL   (gate_RL),
        .fault_flag(fault_flag),
        .dt_active (dt_active)
    );

    pwm_deadtime_gate_chk u_chk (
        .clk_20M(clk_20M),
        .reset  (reset),
        .enable (enable),
        .gate_LU(gate_LU),
        .gate_LL(gate_LL),
        .gate_RU(gate_RU),
        .gate_RL(gate_RL)
    );

    typedef struct {
        logic            rst;
        logic            en;
        logic            flt;
        logic            fclr;
        logic [DT_W-1:0] dt;
        logic            pl;
        logic            pr;
        int              n;
        logic [5:0]      exp;
    } seg_t;

    seg_t       tbl   [$];
    logic [5:0] exp_q [$];
    int         checks   = 0;
    int         failures = 0;
    int         last_side [2];
    int         off_cnt   [2];

    function automatic void add(input logic rst, input logic en,
                                input logic flt, input logic fclr,
                                input int dt, input logic pl, input logic pr,
                                input int n, input logic [5:0] exp);
        seg_t s;
        s.rst  = rst;
        s.en   = en;
        s.flt  = flt;
        s.fclr = fclr;
        s.dt   = DT_W'(dt);
        s.pl   = pl;
        s.pr   = pr;
        s.n    = n;
        s.exp  = exp;
        tbl.push_back(s);
    endfunction

    task automatic run_seg(input seg_t s, input int idx);
        logic [5:0] got;
        logic [5:0] want;
        for (int c = 0; c < s.n; c++) begin
            reset     = s.rst;
            enable    = s.en;
            fault_in  = s.flt;
            fault_clr = s.fclr;
            dead_time = s.dt;
            PWM_left  = s.pl;
            PWM_right = s.pr;
            exp_q.push_back(s.exp);
            @(posedge clk_20M);
            #1;
            got  = {gate_LU, gate_LL, gate_RU, gate_RL, fault_flag, dt_active};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL seg%0d cycle%0d outputs got=%b want=%b",
                         idx, c, got, want);
            end
        end
    endtask

    // Shoot-through and side-change gap check on one leg after an edge.
    task automatic check_leg(input int leg, input logic u, input logic l);
        checks++;
        if (u && l) begin
            failures++;
            $display("FAIL shoot_through leg%0d got u=%b l=%b want not both",
                     leg, u, l);
        end
        if (u || l) begin
            if (off_cnt[leg] > 0 &&
                ((u && last_side[leg] == 2) || (l && last_side[leg] == 1))) begin
                checks++;
                if (off_cnt[leg] < DT_MIN) begin
                    failures++;
                    $display("FAIL dead_gap leg%0d got=%0d want>=%0d",
                             leg, off_cnt[leg], DT_MIN);
                end
            end
            last_side[leg] = u ? 1 : 2;
            off_cnt[leg]   = 0;
        end else begin
            off_cnt[leg] = off_cnt[leg] + 1;
        end
    endtask

    initial begin
        // reset, then release: both legs enter DT_L and lower gates follow
        add(1, 1, 0, 0, 40, 0, 0,  3, 6'b000000);
        add(0, 1, 0, 0, 40, 0, 0, 40, 6'b000001);
        add(0, 1, 0, 0, 40, 0, 0,  1, 6'b010100);
        // left 0->1 with dead_time 40: exactly 40 cycles both off
        add(0, 1, 0, 0, 40, 1, 0,  1, 6'b010100);
        add(0, 1, 0, 0, 40, 1, 0, 40, 6'b000101);
        add(0, 1, 0, 0, 40, 1, 0,  1, 6'b100100);
        // dead_time 3 clamps to 10 on both legs at once
        add(0, 1, 0, 0,  3, 0, 1,  1, 6'b100100);
        add(0, 1, 0, 0,  3, 0, 1, 10, 6'b000001);
        add(0, 1, 0, 0,  3, 0, 1,  1, 6'b011000);
        // 15-cycle left pulse: revert from DT_H, upper never on
        add(0, 1, 0, 0, 40, 1, 1,  1, 6'b011000);
        add(0, 1, 0, 0, 40, 1, 1, 14, 6'b001001);
        add(0, 1, 0, 0, 40, 0, 1,  1, 6'b001001);
        add(0, 1, 0, 0, 40, 0, 1,  1, 6'b011000);
        // command reverts on the edge the count expires: count wins
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b011000);
        add(0, 1, 0, 0, 10, 1, 1,  9, 6'b001001);
        add(0, 1, 0, 0, 10, 0, 1,  1, 6'b001001);
        add(0, 1, 0, 0, 10, 0, 1,  1, 6'b101000);
        add(0, 1, 0, 0, 10, 0, 1,  1, 6'b001001);
        add(0, 1, 0, 0, 10, 0, 1,  9, 6'b001001);
        add(0, 1, 0, 0, 10, 0, 1,  1, 6'b011000);
        // dead_time change mid-count ignored
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b011000);
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b001001);
        add(0, 1, 0, 0, 200, 1, 1, 9, 6'b001001);
        add(0, 1, 0, 0, 200, 1, 1, 1, 6'b101000);
        // one-cycle fault while both legs HIGH
        add(0, 1, 1, 0, 10, 1, 1,  1, 6'b101010);
`ifdef GATE_FAULT_LATCH_EN
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b000010);
        add(0, 1, 0, 0, 10, 1, 1,  5, 6'b000010);
        add(0, 1, 0, 1, 10, 1, 1,  1, 6'b000000);
`else
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b000000);
`endif
        add(0, 1, 0, 0, 10, 1, 1, 10, 6'b000001);
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b010100);
        add(0, 1, 0, 0, 10, 1, 1, 10, 6'b000001);
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b101000);
        // disable, then re-enable through DT_L
        add(0, 0, 0, 0, 10, 1, 1,  1, 6'b000000);
        add(0, 0, 0, 0, 10, 1, 1,  3, 6'b000000);
        add(0, 1, 0, 0, 10, 1, 1, 10, 6'b000001);
        add(0, 1, 0, 0, 10, 1, 1,  1, 6'b010100);
        // reset mid-operation
        add(1, 1, 0, 0, 10, 1, 1,  1, 6'b000000);
        add(0, 1, 0, 0, 10, 0, 0,  1, 6'b000001);

        reset     = 1'b1;
        enable    = 1'b1;
        fault_in  = 1'b0;
        fault_clr = 1'b0;
        dead_time = DT_W'(40);
        PWM_left  = 1'b0;
        PWM_right = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_seg(tbl[i], i);
        end

        // random stream
        reset = 1'b1;
        repeat (2) @(posedge clk_20M);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            last_side[k] = 0;
            off_cnt[k]   = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            enable    = ($urandom_range(0, 63) != 0);
            fault_in  = ($urandom_range(0, 199) == 0);
            fault_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) PWM_left = ~PWM_left;
            if ($urandom_range(0, 9) == 0) PWM_right = ~PWM_right;
            dead_time = DT_W'($urandom_range(0, 25));
            @(posedge clk_20M);
            #1;
            check_leg(0, gate_LU, gate_LL);
            check_leg(1, gate_RU, gate_RL);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
